rr_mux_arbiter: RTL and testbench
=================================

// Module: rr_mux_arbiter
// PURPOSE
//   Round-robin arbiter that shares one WIDTH-bit output channel among four requesters.
//   It drives the select of the 4:1 channel mux, which is built from mux2_1 cells,
//   and the one-hot grant vector.
//   It also issues per-beat acknowledges and caps each grant at MAX_HOLD accepted beats.
//   Sits between four producer ports and a single ready/valid consumer.
// PARAMETERS
//   WIDTH     8   data width of each requester and of out_data
//   MAX_HOLD  4   max beats accepted per grant before forced release (>=1)
// PORTS
//   clock     in   1         rising-edge clock
//   reset     in   1         synchronous, active-high reset
//   req       in   4         req[i]=1: requester i has a beat on its data slice
//   in_data   in   4*WIDTH   requester i data at [i*WIDTH +: WIDTH]
//   out_ready in   1         consumer accepts out_data this cycle when high
//   out_valid out  1         out_data holds a valid beat
//   out_data  out  WIDTH     muxed data of granted requester (in_data slice sel)
//   sel       out  2         mux select = index of current/last grant holder
//   gnt       out  4         one-hot grant, all-zero when idle
//   ack       out  4         ack[i] pulses for each accepted beat of requester i
// BEHAVIOUR
//   Reset: state=IDLE, ptr=0, sel=0, gnt=0, cnt=0; out_valid=0, ack=0.
//   Reset mid-transfer: grant dropped on that edge; a beat in that cycle is not acked.
//   States: IDLE, BUSY (state, ptr, sel, gnt, cnt registered).
//   IDLE:
//     if |req, choose the first i with req[i]=1 scanning ptr, ptr+1, .. mod 4;
//     next edge: sel<=i, gnt<=1<<i, cnt<=0, state<=BUSY.
//     Latency req->gnt = 1 cycle. No req: stay IDLE, sel holds.
//   BUSY (combinational outputs):
//     out_valid = req[sel]; out_data = in_data[sel*WIDTH +: WIDTH] (also while idle);
//     accept = out_valid & out_ready; ack = accept ? gnt : 0.
//   BUSY transitions (evaluated per cycle):
//     req[sel]=0 -> release.
//     accept & cnt==MAX_HOLD-1 -> release.
//     accept otherwise -> cnt<=cnt+1, stay.
//     out_ready=0 -> hold everything; data must be stable from requester.
//   Release: state<=IDLE, gnt<=0, ptr<=sel+1 mod 4 (3 wraps to 0), cnt<=0.
//     sel keeps last winner.
//   One idle bubble always follows a release; the next grant appears 2 edges after the release cycle.
//   Requests from non-granted ports never disturb the current grant.
//   A requester dropping req while out_ready=1 on the same cycle: no beat, release.
//   MAX_HOLD=1: every accepted beat releases the grant.
//   cnt width = clog2(MAX_HOLD) (min 1); never exceeds MAX_HOLD-1.
//   ack is one-hot or zero; out_valid=0 whenever gnt=0.
// TESTING
//   1 reset=1 for 2 cycles, req=4'hF -> gnt=0, out_valid=0, ack=0, sel=0 throughout.
//   2 req=4'b0100, data2=8'hA5, out_ready=1 ->
//     gnt=4'b0100 one cycle later, sel=2, out_data=A5, ack[2] pulses each beat.
//   3 req=4'hF held, out_ready=1, MAX_HOLD=4 -> grants 0,1,2,3,0 in order.
//     Each grant gets exactly 4 acks, then a 1-cycle idle bubble.
//   4 Grant held by 3 -> ptr wraps to 0.
//     req=4'b1001 after release -> next grant to 0, not 3.
//   5 Granted port 1, out_ready=0 for 5 cycles -> no ack, cnt stays 0.
//     out_data stable; then out_ready=1 -> 4 acks, then release.
//   6 Reset asserted mid-grant (cnt=2) -> next edge gnt=0, state IDLE, ptr=0.
//     After reset: req=4'b0010 -> gnt=4'b0010.

Source files
------------

// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - four-port round-robin arbiter driving a mux2_1-based channel mux
module mux2_1 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] y
);
  assign y = s ? b : a;
endmodule

module rr_mux_arbiter #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] in_data,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         sel,
  output logic [3:0]         gnt,
  output logic [3:0]         ack
);

  localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_HOLD - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_nx;
  logic [1:0]    ptr, ptr_nx;
  logic [1:0]    sel_nx;
  logic [3:0]    gnt_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          accept;
  logic [1:0]    pick;
  logic          pick_vld;
  logic [1:0]    scan_idx;
  logic [WIDTH-1:0] mux_lo, mux_hi;

  // Two-level tree of 2:1 cells: sel[0] picks within a pair, sel[1] picks the pair.
  mux2_1 #(.WIDTH(WIDTH)) u_mux_lo (
    .a(in_data[0*WIDTH +: WIDTH]), .b(in_data[1*WIDTH +: WIDTH]), .s(sel[0]), .y(mux_lo)
  );
  mux2_1 #(.WIDTH(WIDTH)) u_mux_hi (
    .a(in_data[2*WIDTH +: WIDTH]), .b(in_data[3*WIDTH +: WIDTH]), .s(sel[0]), .y(mux_hi)
  );
  mux2_1 #(.WIDTH(WIDTH)) u_mux_out (
    .a(mux_lo), .b(mux_hi), .s(sel[1]), .y(out_data)
  );

  // Round-robin scan from ptr; walking offsets high-to-low lets the nearest requester win.
  always_comb begin
    pick     = ptr;
    pick_vld = 1'b0;
    scan_idx = ptr;
    for (int k = 3; k >= 0; k--) begin
      scan_idx = ptr + 2'(k);
      if (req[scan_idx]) begin
        pick     = scan_idx;
        pick_vld = 1'b1;
      end
    end
  end

  // State register: grant bookkeeping, cleared synchronously by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= 2'd0;
      sel   <= 2'd0;
      gnt   <= 4'd0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      sel   <= sel_nx;
      gnt   <= gnt_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state logic: grant from IDLE, count beats and release from BUSY.
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    sel_nx   = sel;
    gnt_nx   = gnt;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nx = BUSY;
          sel_nx   = pick;
          gnt_nx   = 4'b0001 << pick;
          cnt_nx   = '0;
        end
      end
      BUSY: begin
        if (!req[sel] || (accept && cnt == CNT_LAST)) begin
          // Release: the winner's successor gets first look next time; sel keeps the winner.
          state_nx = IDLE;
          gnt_nx   = 4'd0;
          ptr_nx   = sel + 2'd1;
          cnt_nx   = '0;
        end else if (accept) begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        gnt_nx   = 4'd0;
        cnt_nx   = '0;
      end
    endcase
  end

  // Outputs: a beat moves only while granted, never in a reset cycle.
  always_comb begin
    out_valid = (state == BUSY) && req[sel] && !reset;
    accept    = out_valid && out_ready;
    ack       = accept ? gnt : 4'd0;
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb/tb_rr_mux_arbiter.sv - scoreboard bench for rr_mux_arbiter
module tb_rr_mux_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] in_data;
  logic        out_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  sel;
  logic [3:0]  gnt;
  logic [3:0]  ack;

  rr_mux_arbiter #(.WIDTH(8), .MAX_HOLD(4)) dut (
    .clock(clock), .reset(reset), .req(req), .in_data(in_data),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .sel(sel), .gnt(gnt), .ack(ack)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    int         port;
    logic [3:0] ack;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [7:0] pdata [4];
  int   c0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_beats(input int port, input int c, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.cyc  = c + i;
      e.port = port;
      e.ack  = 4'b0001 << port;
      e.data = pdata[port];
      sb.push_back(e);
    end
  endtask

  task automatic step_to(input int n);
    while (cyc < n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Monitor: every acknowledged beat must match the next expected beat.
  always @(negedge clock) begin
    if (ack !== 4'b0000) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_ack: got ack=%b at cycle %0d expected none", ack, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("beat_cycle", 32'(cyc), 32'(mon_e.cyc));
        chk("beat_ack", 32'(ack), 32'(mon_e.ack));
        chk("beat_data", 32'(out_data), 32'(mon_e.data));
        chk("beat_sel", 32'(sel), 32'(mon_e.port));
        chk("beat_valid", 32'(out_valid), 32'd1);
      end
    end
  end

  initial begin
    pdata[0] = 8'h11;
    pdata[1] = 8'h5A;
    pdata[2] = 8'hA5;
    pdata[3] = 8'hC3;
    in_data   = {8'hC3, 8'hA5, 8'h5A, 8'h11};
    reset     = 1'b1;
    req       = 4'hF;
    out_ready = 1'b1;

    // reset held with all requests active
    @(posedge clock); #1;
    repeat (2) begin
      #3;
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_sel", 32'(sel), 32'd0);
      @(posedge clock); #1;
    end

    // single requester 2
    reset = 1'b0;
    req   = 4'b0100;
    c0    = cyc;
    push_beats(2, c0 + 1, 4);
    #3;
    chk("t2_gnt_latency", 32'(gnt), 32'd0);
    step_to(c0 + 1); #3;
    chk("t2_gnt", 32'(gnt), 32'b0100);
    chk("t2_sel", 32'(sel), 32'd2);
    chk("t2_data", 32'(out_data), 32'hA5);
    chk("t2_valid", 32'(out_valid), 32'd1);
    step_to(c0 + 5);
    req = 4'b0000;
    #3;
    chk("t2_release", 32'(gnt), 32'd0);
    step_to(c0 + 6);
    reset = 1'b1;
    step_to(c0 + 7);
    reset = 1'b0;

    // all four requesting: 0,1,2,3,0 with a bubble between grants
    req = 4'hF;
    c0  = cyc;
    for (int k = 0; k < 5; k++) push_beats(k % 4, c0 + 1 + 5 * k, 4);
    step_to(c0 + 5); #3;
    chk("t3_bubble", 32'(gnt), 32'd0);
    chk("t3_bubble_valid", 32'(out_valid), 32'd0);
    step_to(c0 + 6); #3;
    chk("t3_second_gnt", 32'(gnt), 32'b0010);
    step_to(c0 + 25);
    req = 4'b0000;
    #3;
    chk("t3_end_gnt", 32'(gnt), 32'd0);

    // requester 3 then pointer wrap to 0
    step_to(c0 + 26);
    c0  = cyc;
    req = 4'b1000;
    push_beats(3, c0 + 1, 4);
    step_to(c0 + 1); #3;
    chk("t4_gnt3", 32'(gnt), 32'b1000);
    step_to(c0 + 5);
    req = 4'b1001;
    push_beats(0, c0 + 6, 4);
    step_to(c0 + 6); #3;
    chk("t4_wrap_gnt", 32'(gnt), 32'b0001);
    chk("t4_wrap_sel", 32'(sel), 32'd0);
    step_to(c0 + 10);
    req = 4'b0000;

    // requester 1 stalled by the consumer for 5 cycles
    step_to(c0 + 11);
    c0        = cyc;
    req       = 4'b0010;
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step_to(c0 + i); #3;
      chk("t5_stall_ack", 32'(ack), 32'd0);
      chk("t5_stall_data", 32'(out_data), 32'h5A);
      chk("t5_stall_gnt", 32'(gnt), 32'b0010);
    end
    step_to(c0 + 6);
    out_ready = 1'b1;
    push_beats(1, c0 + 6, 4);
    step_to(c0 + 10);
    req = 4'b0000;
    #3;
    chk("t5_release", 32'(gnt), 32'd0);

    // reset in the middle of a grant
    step_to(c0 + 11);
    c0  = cyc;
    req = 4'b0100;
    push_beats(2, c0 + 1, 2);
    step_to(c0 + 3);
    reset = 1'b1;
    #3;
    chk("t6_rst_ack", 32'(ack), 32'd0);
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    step_to(c0 + 4);
    reset = 1'b0;
    req   = 4'b1010;
    #3;
    chk("t6_post_gnt", 32'(gnt), 32'd0);
    chk("t6_post_sel", 32'(sel), 32'd0);
    chk("t6_post_valid", 32'(out_valid), 32'd0);
    push_beats(1, c0 + 5, 4);
    step_to(c0 + 5); #3;
    chk("t6_regrant", 32'(gnt), 32'b0010);
    step_to(c0 + 9);
    req = 4'b0000;

    step_to(c0 + 12);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
